mem_io_responder: RTL

- Responder end of the CPU byte-wide memory bus: CPU address, write-data and write-strobe in; read-data out.
- Backs the bus with a 128 KB synchronous RAM and decodes the I/O window at 0x30000–0x30007.
- Buffers UART output bytes in a TX FIFO and UART input bytes in an RX FIFO, keeps the free-running cycle counter, and flags program stop.
- Drives the CPU pause line when an I/O access cannot complete.

---
 rtl/mem_io_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: 128 KB RAM, a small I/O window with
// UART TX/RX FIFOs, a free-running cycle counter and a sticky stop flag.
// rdy_out is combinational so a blocked I/O access stalls the CPU in the
// same cycle it is presented.
module mem_io_responder #(
  parameter int RAM_AW       = 17,
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_done
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] TX_PTR_ONE = 1;
  localparam logic [RX_DEPTH_LOG:0] RX_PTR_ONE = 1;

  logic [7:0]  r_mem [0:(1 << RAM_AW)-1];
  logic [7:0]  r_ram_q;
  logic [7:0]  r_io_q;
  logic        r_sel_ram;
  logic [31:0] r_cycle;
  logic        r_done;

  logic [7:0]            r_tx_mem [0:TX_DEPTH-1];
  logic [TX_DEPTH_LOG:0] r_tx_wp, r_tx_rp;
  logic [7:0]            r_rx_mem [0:RX_DEPTH-1];
  logic [RX_DEPTH_LOG:0] r_rx_wp, r_rx_rp;

  logic       w_unused_addr;
  logic       w_ram, w_io_win;
  logic [2:0] w_off;
  logic       w_tx_req, w_rx_rd_req;
  logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic       w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic       w_acc;
  logic [7:0] w_tx_wdata;
  logic [7:0] w_io_rd;

  // Only cpu_a[17:0] is decoded; 0x2xxxx is a hole, 0x3xxxx is I/O.
  assign w_unused_addr = ^cpu_a[31:18];
  assign w_ram         = ~cpu_a[17];
  assign w_io_win      = (cpu_a[17:16] == 2'b11) && (cpu_a[15:3] == 13'd0);
  assign w_off         = cpu_a[2:0];

  // A zero byte written to the TX port is dropped; the stop write queues a 0x00 marker.
  assign w_tx_req    = cpu_wr & w_io_win & (((w_off == 3'd0) && (cpu_dout != 8'd0)) || (w_off == 3'd4));
  assign w_rx_rd_req = ~cpu_wr & w_io_win & (w_off == 3'd0);
  assign w_tx_wdata  = (w_off == 3'd4) ? 8'd0 : cpu_dout;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[TX_DEPTH_LOG] != r_tx_rp[TX_DEPTH_LOG]) &&
                      (r_tx_wp[TX_DEPTH_LOG-1:0] == r_tx_rp[TX_DEPTH_LOG-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[RX_DEPTH_LOG] != r_rx_rp[RX_DEPTH_LOG]) &&
                      (r_rx_wp[RX_DEPTH_LOG-1:0] == r_rx_rp[RX_DEPTH_LOG-1:0]);

  // A same-cycle UART pop frees a TX slot; a same-cycle RX push does not satisfy a read.
  assign w_tx_pop  = ~w_tx_empty & tx_ready;
  assign rdy_out   = ~((w_tx_req & w_tx_full & ~w_tx_pop) | (w_rx_rd_req & w_rx_empty));
  assign w_acc     = rdy_out;
  assign w_tx_push = w_acc & w_tx_req;
  assign w_rx_pop  = w_acc & w_rx_rd_req;
  assign w_rx_push = rx_valid & ~w_rx_full;

  assign tx_valid     = ~w_tx_empty;
  assign tx_data      = r_tx_mem[r_tx_rp[TX_DEPTH_LOG-1:0]];
  assign rx_full      = w_rx_full;
  assign program_done = r_done;
  assign cpu_din      = r_sel_ram ? r_ram_q : r_io_q;

  // I/O read data for the current address.
  always_comb begin
    w_io_rd = 8'd0;
    if (w_io_win) begin
      case (w_off)
        3'd0:    w_io_rd = r_rx_mem[r_rx_rp[RX_DEPTH_LOG-1:0]];
        3'd4:    w_io_rd = r_cycle[7:0];
        3'd5:    w_io_rd = r_cycle[15:8];
        3'd6:    w_io_rd = r_cycle[23:16];
        3'd7:    w_io_rd = r_cycle[31:24];
        default: w_io_rd = 8'd0;
      endcase
    end
  end

  // RAM array with registered read port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (w_acc && w_ram) begin
      if (cpu_wr) r_mem[cpu_a[RAM_AW-1:0]] <= cpu_dout;
      else        r_ram_q <= r_mem[cpu_a[RAM_AW-1:0]];
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk_in) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TX_DEPTH_LOG-1:0]] <= w_tx_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp[RX_DEPTH_LOG-1:0]] <= rx_data;
  end

  // Read-data select/hold, FIFO pointers, cycle counter and stop flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sel_ram <= 1'b0;
      r_io_q    <= 8'd0;
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_cycle   <= 32'd0;
      r_done    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_acc && !cpu_wr) begin
        r_sel_ram <= w_ram;
        if (!w_ram) r_io_q <= w_io_rd;
      end
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PTR_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PTR_ONE;
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_PTR_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_PTR_ONE;
      if (w_acc && cpu_wr && w_io_win && (w_off == 3'd4)) r_done <= 1'b1;
    end
  end

endmodule
